vpifo_push_ingress: RTL



---
 rtl/vpifo_pkg.sv | 16 +
 rtl/vpifo_ingress_fifo.sv | 42 ++++
 rtl/vpifo_push_ingress.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vpifo_pkg.sv
// Shared vPIFO types and default widths for the push path.
package vpifo_pkg;

   localparam int unsigned PTW_DEF           = 16;
   localparam int unsigned TREE_NUM_DEF      = 5;
   localparam int unsigned TREE_NUM_BITS_DEF = $clog2(TREE_NUM_DEF);
   localparam int unsigned MTW_DEF           = TREE_NUM_BITS_DEF;

   // Push request as seen by the task generator (default configuration).
   typedef struct packed {
      logic [TREE_NUM_BITS_DEF-1:0]   tree_id;
      logic [PTW_DEF-1:0]             prio;
      logic [MTW_DEF+PTW_DEF-1:0]     data;
   } push_req_t;

endpackage

// File: rtl/vpifo_ingress_fifo.sv
// Small in-order request FIFO; pointers carry an extra wrap bit for full/empty.
module vpifo_ingress_fifo
   import vpifo_pkg::*;
#(
   parameter type T = push_req_t,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  T     wr_data,
   input  logic rd_en,
   output T     rd_data_c,
   output logic full_c,
   output logic empty_c
);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   T            mem [DEPTH];

   assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty_c   = (wr_ptr == rd_ptr);
   assign rd_data_c = mem[rd_ptr[AW-1:0]];

   // Storage is cleared on reset so the head presents zeros while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en && !full_c) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en && !empty_c) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/vpifo_push_ingress.sv
// Push ingress ahead of the vPIFO task generator: buffering, per-tree caps, occupancy.
// Optional counters o_drop_cnt/o_stall_cnt under VPIFO_INGRESS_STATS_EN.
module vpifo_push_ingress
   import vpifo_pkg::*;
#(
   parameter int unsigned PTW      = PTW_DEF,
   parameter int unsigned TREE_NUM = TREE_NUM_DEF,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TREE_CAP = 512,
   localparam int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
   localparam int unsigned MTW           = TREE_NUM_BITS,
   localparam int unsigned OCC_BITS      = $clog2(TREE_CAP + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [TREE_NUM_BITS-1:0] i_in_tree_id,
   input  logic [PTW-1:0]           i_in_priority,
   input  logic [MTW+PTW-1:0]       i_in_data,
   output logic                     o_push,
   output logic [TREE_NUM_BITS-1:0] o_push_tree_id,
   output logic [PTW-1:0]           o_push_priority,
   output logic [MTW+PTW-1:0]       o_push_data,
   input  logic                     i_task_fifo_full,
   input  logic                     i_pop,
   input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
   output logic                     o_drop,
   output logic                     o_underflow
`ifdef VPIFO_INGRESS_STATS_EN
   ,
   output logic [15:0]              o_drop_cnt,
   output logic [31:0]              o_stall_cnt
`endif
);

   typedef struct packed {
      logic [TREE_NUM_BITS-1:0] tree_id;
      logic [PTW-1:0]           prio;
      logic [MTW+PTW-1:0]       data;
   } req_t;

   req_t                 wr_req;
   req_t                 head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 accept;
   logic                 tree_ok;
   logic                 pop_ok;
   logic                 issue;
   logic [OCC_BITS-1:0]  occ [TREE_NUM];
   logic [OCC_BITS-1:0]  head_occ;
   logic [TREE_NUM-1:0]  inc;
   logic [TREE_NUM-1:0]  dec;

   assign o_in_ready = !fifo_full;
   assign accept     = i_in_valid && o_in_ready;
   assign tree_ok    = {1'b0, i_in_tree_id}  < (TREE_NUM_BITS+1)'(TREE_NUM);
   assign pop_ok     = i_pop && ({1'b0, i_pop_tree_id} < (TREE_NUM_BITS+1)'(TREE_NUM));
   assign wr_req     = '{tree_id: i_in_tree_id, prio: i_in_priority, data: i_in_data};

   vpifo_ingress_fifo #(
      .T     (req_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .wr_en     (accept && tree_ok),
      .wr_data   (wr_req),
      .rd_en     (issue),
      .rd_data_c (head),
      .full_c    (fifo_full),
      .empty_c   (fifo_empty)
   );

   // Only in-range tree ids are ever enqueued, so the head always indexes a real tree.
   assign head_occ = occ[head.tree_id];
   assign issue    = !fifo_empty && !i_task_fifo_full && (head_occ < OCC_BITS'(TREE_CAP));

   assign o_push          = issue;
   assign o_push_tree_id  = head.tree_id;
   assign o_push_priority = head.prio;
   assign o_push_data     = head.data;

   always_comb begin
      inc = '0;
      dec = '0;
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
         inc[t] = issue  && (head.tree_id   == TREE_NUM_BITS'(t));
         dec[t] = pop_ok && (i_pop_tree_id  == TREE_NUM_BITS'(t));
      end
   end

   // Issue and pop on the same tree cancel; a pop at zero holds and flags underflow.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned t = 0; t < TREE_NUM; t++) occ[t] <= '0;
         o_drop      <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_drop <= accept && !tree_ok;
         for (int unsigned t = 0; t < TREE_NUM; t++) begin
            if (inc[t] && !dec[t]) begin
               occ[t] <= occ[t] + OCC_BITS'(1);
            end else if (dec[t] && !inc[t]) begin
               if (occ[t] != '0) occ[t] <= occ[t] - OCC_BITS'(1);
               else              o_underflow <= 1'b1;
            end
         end
      end
   end

`ifdef VPIFO_INGRESS_STATS_EN
   // Saturating event counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_drop_cnt  <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (accept && !tree_ok && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 16'(1);
         if (!fifo_empty && !issue && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + 32'(1);
      end
   end
`endif

endmodule
